// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer in front of the shared data
// memory. It accepts one request at a time from m0 (core) or m1 (debug/DMA),
// rejects illegal accesses without touching memory, and drives the memory
// for exactly one cycle per legal access. The response is returned, tagged,
// to the port that issued the request.
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [1:0]            m0_req_maskmode,
  input  logic                  m0_req_sext,
  input  logic [DATA_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [1:0]            m1_req_maskmode,
  input  logic                  m1_req_sext,
  input  logic [DATA_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,

  output logic                  dm_mem_write,
  output logic                  dm_mem_read,
  output logic [1:0]            dm_maskmode,
  output logic                  dm_sext,
  output logic [DATA_WIDTH-1:0] dm_address,
  output logic [DATA_WIDTH-1:0] dm_write_data,
  input  logic [DATA_WIDTH-1:0] dm_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    req_id_r;
  logic                    req_we_r;
  logic                    rsp_valid_r;
  logic                    rsp_err_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;

  logic                    grant_valid;
  logic                    grant_id;
  logic                    g_we;
  logic [1:0]              g_maskmode;
  logic                    g_sext;
  logic [DATA_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wdata;
  logic                    own_rsp_ready;

  // An access is legal when the size is defined, the address is naturally
  // aligned for that size, and it falls inside the memory.
  function automatic logic req_legal(input logic [1:0] mm,
                                     input logic [DATA_WIDTH-1:0] a);
    logic ok;
    ok = ((a >> (MEM_ADDR_SIZE + 2)) == '0);
    case (mm)
      2'b00:   ok = ok;
      2'b01:   if (a[0]) ok = 1'b0;
      2'b10:   if (a[1:0] != 2'b00) ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the port that
  // was not served last.
  always_comb begin
    grant_valid = m0_req_valid | m1_req_valid;
    if (m0_req_valid && m1_req_valid) grant_id = ~last_grant;
    else                              grant_id = m1_req_valid;
    g_we       = grant_id ? m1_req_we       : m0_req_we;
    g_maskmode = grant_id ? m1_req_maskmode : m0_req_maskmode;
    g_sext     = grant_id ? m1_req_sext     : m0_req_sext;
    g_addr     = grant_id ? m1_req_addr     : m0_req_addr;
    g_wdata    = grant_id ? m1_req_wdata    : m0_req_wdata;
    own_rsp_ready = req_id_r ? m1_rsp_ready : m0_rsp_ready;
  end

  // Ready is offered only in IDLE and only to the granted port; it is held
  // low while reset is asserted.
  assign m0_req_ready = rstn && (state == IDLE) && grant_valid && !grant_id;
  assign m1_req_ready = rstn && (state == IDLE) && grant_valid &&  grant_id;

  // The response is steered to the owning port; the other port sees zeros.
  assign m0_rsp_valid = rsp_valid_r & ~req_id_r;
  assign m1_rsp_valid = rsp_valid_r &  req_id_r;
  assign m0_rsp_err   = rsp_err_r   & ~req_id_r;
  assign m1_rsp_err   = rsp_err_r   &  req_id_r;
  assign m0_rsp_rdata = req_id_r ? '0 : rsp_rdata_r;
  assign m1_rsp_rdata = req_id_r ? rsp_rdata_r : '0;

  // Sequencer: accept, access memory for one cycle, then hold the response
  // until the owner consumes it. Memory controls are registered and exist
  // only in ACCESS; reset drops them at once so a pending store never commits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      req_id_r      <= 1'b0;
      req_we_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_rdata_r   <= '0;
      dm_mem_write  <= 1'b0;
      dm_mem_read   <= 1'b0;
      dm_maskmode   <= 2'b00;
      dm_sext       <= 1'b0;
      dm_address    <= '0;
      dm_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            req_id_r   <= grant_id;
            req_we_r   <= g_we;
            last_grant <= grant_id;
            if (req_legal(g_maskmode, g_addr)) begin
              state         <= ACCESS;
              dm_mem_write  <= g_we;
              dm_mem_read   <= ~g_we;
              dm_maskmode   <= g_maskmode;
              dm_sext       <= g_sext;
              dm_address    <= g_addr;
              dm_write_data <= g_wdata;
            end else begin
              state       <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end
          end
        end
        ACCESS: begin
          state         <= RESP;
          rsp_valid_r   <= 1'b1;
          rsp_err_r     <= 1'b0;
          rsp_rdata_r   <= req_we_r ? '0 : dm_read_data;
          dm_mem_write  <= 1'b0;
          dm_mem_read   <= 1'b0;
          dm_maskmode   <= 2'b00;
          dm_sext       <= 1'b0;
          dm_address    <= '0;
          dm_write_data <= '0;
        end
        RESP: begin
          if (own_rsp_ready) begin
            state       <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural data memory, per-port response
// scoreboards and directed scenarios.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_req_sext;
  logic [1:0]  m0_req_maskmode;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
  logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_req_sext;
  logic [1:0]  m1_req_maskmode;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic        dm_mem_write, dm_mem_read, dm_sext;
  logic [1:0]  dm_maskmode;
  logic [31:0] dm_address, dm_write_data, dm_read_data;

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];
  int   glog[$];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cycles = 0;
  int both_ready_viol = 0;
  int both_rsp_viol = 0;
  int quiet_viol = 0;
  bit mem_quiet = 0;

  logic [31:0] mem [256];

  dmem_arbiter #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_maskmode(m0_req_maskmode), .m0_req_sext(m0_req_sext), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_maskmode(m1_req_maskmode), .m1_req_sext(m1_req_sext), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .dm_mem_write(dm_mem_write), .dm_mem_read(dm_mem_read), .dm_maskmode(dm_maskmode),
    .dm_sext(dm_sext), .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_read_data(dm_read_data)
  );

  always #5 clk = ~clk;

  // Memory: combinational read with size/extension, write on negedge.
  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[dm_address[9:2]];
    b = w[{dm_address[1:0], 3'b000} +: 8];
    h = w[{dm_address[1], 4'b0000} +: 16];
    dm_read_data = w;
    case (dm_maskmode)
      2'b00:   dm_read_data = dm_sext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   dm_read_data = dm_sext ? {16'h0, h} : {{16{h[15]}}, h};
      default: dm_read_data = w;
    endcase
  end

  always @(negedge clk) begin
    if (dm_mem_write) begin
      case (dm_maskmode)
        2'b00:   mem[dm_address[9:2]][{dm_address[1:0], 3'b000} +: 8] <= dm_write_data[7:0];
        2'b01:   mem[dm_address[9:2]][{dm_address[1], 4'b0000} +: 16] <= dm_write_data[15:0];
        default: mem[dm_address[9:2]] <= dm_write_data;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Protocol monitors and response scoreboards.
  always @(negedge clk) begin
    if (rstn) begin
      if (dm_mem_write) wr_cycles++;
      if (m0_req_ready && m1_req_ready) both_ready_viol++;
      if (m0_rsp_valid && m1_rsp_valid) both_rsp_viol++;
      if (mem_quiet && (dm_mem_read || dm_mem_write)) quiet_viol++;
      if (m0_req_valid && m0_req_ready) glog.push_back(0);
      if (m1_req_valid && m1_req_ready) glog.push_back(1);
      if (m0_rsp_valid && m0_rsp_ready) begin
        if (q0.size() == 0) check("m0_unexpected_rsp", {31'h0, m0_rsp_valid}, 32'h0);
        else begin
          rsp_t e;
          e = q0.pop_front();
          check("m0_rdata", m0_rsp_rdata, e.rdata);
          check("m0_err", {31'h0, m0_rsp_err}, {31'h0, e.err});
        end
      end
      if (m1_rsp_valid && m1_rsp_ready) begin
        if (q1.size() == 0) check("m1_unexpected_rsp", {31'h0, m1_rsp_valid}, 32'h0);
        else begin
          rsp_t e;
          e = q1.pop_front();
          check("m1_rdata", m1_rsp_rdata, e.rdata);
          check("m1_err", {31'h0, m1_rsp_err}, {31'h0, e.err});
        end
      end
    end
  end

  function automatic logic rdy(input int p);
    return (p == 0) ? m0_req_ready : m1_req_ready;
  endfunction

  function automatic logic rv(input int p);
    return (p == 0) ? m0_rsp_valid : m1_rsp_valid;
  endfunction

  task automatic drive(input int p, input logic v, input logic we, input logic [1:0] mm,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req_valid = v; m0_req_we = we; m0_req_maskmode = mm;
      m0_req_sext = sx; m0_req_addr = a; m0_req_wdata = wd;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_maskmode = mm;
      m1_req_sext = sx; m1_req_addr = a; m1_req_wdata = wd;
    end
  endtask

  // Issue one request, push its expected response, wait for the handshake
  // and optionally check latency and the memory-side access cycle.
  task automatic issue(input int p, input logic we, input logic [1:0] mm, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input bit chk_lat);
    int n;
    rsp_t e;
    e.rdata = erd;
    e.err = eerr;
    @(posedge clk); #1;
    drive(p, 1'b1, we, mm, sx, a, wd);
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy(p)) break;
      n++;
      if (n > 100) begin
        check("handshake_timeout", {31'h0, rdy(p)}, 32'h1);
        drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        if (p == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        return;
      end
    end
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    if (chk_lat) begin
      @(negedge clk);
      if (eerr) begin
        check("lat_err_T1", {31'h0, rv(p)}, 32'h1);
        check("err_no_mem", {30'h0, dm_mem_read, dm_mem_write}, 32'h0);
      end else begin
        check("lat_T1_low", {31'h0, rv(p)}, 32'h0);
        check("acc_write", {31'h0, dm_mem_write}, {31'h0, we});
        check("acc_read", {31'h0, dm_mem_read}, {31'h0, ~we});
        check("acc_addr", dm_address, a);
        check("acc_mask", {30'h0, dm_maskmode}, {30'h0, mm});
        check("acc_sext", {31'h0, dm_sext}, {31'h0, sx});
        if (we) check("acc_wdata", dm_write_data, wd);
        @(negedge clk);
        check("lat_T2", {31'h0, rv(p)}, 32'h1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int snap;
    logic [31:0] held;
    int n;
    foreach (mem[i]) mem[i] = 32'h0;
    rstn = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_m0_req_ready", {31'h0, m0_req_ready}, 32'h0);
    check("rst_rsp", {28'h0, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err}, 32'h0);
    check("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'h0);
    check("rst_dm_ctl", {27'h0, dm_mem_write, dm_mem_read, dm_maskmode, dm_sext}, 32'h0);
    check("rst_dm_data", dm_address | dm_write_data, 32'h0);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1 rstn = 1'b1;

    // Store then load a word on m0
    snap = wr_cycles;
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    check("store_write_cycles", wr_cycles - snap, 32'd1);

    // Illegal requests on m1
    mem_quiet = 1;
    issue(1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    mem_quiet = 0;
    check("illegal_no_mem_access", quiet_viol, 32'd0);

    // Both ports held valid: grants alternate starting with m0
    glog.delete();
    fork
      begin
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      end
      issue(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    join
    repeat (4) @(posedge clk);
    check("grant_count", glog.size(), 32'd3);
    if (glog.size() == 3) begin
      check("grant0", glog[0], 32'd0);
      check("grant1", glog[1], 32'd1);
      check("grant2", glog[2], 32'd0);
    end

    // m0 response stalled for 5 cycles while m1 waits
    @(posedge clk); #1 m0_rsp_ready = 1'b0;
    fork
      issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        issue(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m0_rsp_valid && n < 30);
        check("stall_rsp_seen", {31'h0, m0_rsp_valid}, 32'h1);
        held = m0_rsp_rdata;
        check("stall_rdata_first", held, 32'hDEADBEEF);
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", {31'h0, m0_rsp_valid}, 32'h1);
          check("stall_rdata", m0_rsp_rdata, held);
          check("stall_m1_ready", {31'h0, m1_req_ready}, 32'h0);
        end
        @(posedge clk); #1 m0_rsp_ready = 1'b1;
        @(negedge clk);
        check("m1_ready_consume_cycle", {31'h0, m1_req_ready}, 32'h0);
        @(negedge clk);
        check("m1_ready_after_consume", {31'h0, m1_req_ready}, 32'h1);
      end
    join
    repeat (4) @(posedge clk);

    // Byte load with sign vs zero extension
    issue(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h000000F0, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'hFFFFFFF0, 1'b0, 1'b1);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 32'h000000F0, 1'b0, 1'b1);

    // Reset during the access cycle of a store drops the store
    issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h22222222, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0_req_ready && n < 20);
    @(posedge clk); #1;
    check("rst_mid_pre_write", {31'h0, dm_mem_write}, 32'h1);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_dm_ctl", {28'h0, dm_mem_write, dm_mem_read, dm_maskmode}, 32'h0);
    check("rst_mid_dm_addr", dm_address | dm_write_data, 32'h0);
    check("rst_mid_rsp", {30'h0, m0_rsp_valid, m0_rsp_err}, 32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    issue(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h22222222, 1'b0, 1'b1);
    repeat (4) @(posedge clk);

    check("never_both_req_ready", both_ready_viol, 32'd0);
    check("never_both_rsp_valid", both_rsp_viol, 32'd0);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the shared data memory.
- Port m0 is the core load/store path; port m1 is a secondary master (debug/DMA loader).
- Accepts one request at a time using round-robin priority, checks legality, and drives the data memory's access-control, address and write-data inputs for exactly one access cycle.
- Captures read data and returns a tagged response to the originating port over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of address, write-data and read-data words.
- MEM_ADDR_SIZE, 8, log2 of memory depth in words; legal byte addresses are 0 .. 4*2**MEM_ADDR_SIZE-1.

Ports:
- clk  input  1  system clock; memory writes commit on its negedge.
- rstn  input  1  asynchronous, active-low reset.
- m{0,1}_req_valid  input  1  request present.
- m{0,1}_req_ready  output  1  request accepted this cycle (handshake on valid&ready at posedge).
- m{0,1}_req_we  input  1  1 = store, 0 = load.
- m{0,1}_req_maskmode  input  2  00 byte, 01 half, 10 word, 11 illegal.
- m{0,1}_req_sext  input  1  extension select, passed unchanged to memory (0 = sign-extend, 1 = zero-extend).
- m{0,1}_req_addr  input  DATA_WIDTH  byte address.
- m{0,1}_req_wdata  input  DATA_WIDTH  store data.
- m{0,1}_rsp_valid  output  1  response available.
- m{0,1}_rsp_ready  input  1  response consumed.
- m{0,1}_rsp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- m{0,1}_rsp_err  output  1  request was illegal; memory was not accessed.
- dm_mem_write  output  1  to memory write enable.
- dm_mem_read  output  1  to memory read enable.
- dm_maskmode  output  2  to memory access-size select.
- dm_sext  output  1  to memory extension select.
- dm_address  output  DATA_WIDTH  to memory address.
- dm_write_data  output  DATA_WIDTH  to memory write data.
- dm_read_data  input  DATA_WIDTH  from memory; combinational read data.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, last_grant=1 (so m0 wins the first tie).
  - All req_ready, rsp_valid, rsp_err, rsp_rdata and all dm_* outputs are 0.
  - Request and response registers are cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one port has req_valid=1, that port is granted.
  - If both are valid, the port != last_grant is granted.
  - req_ready=1 combinationally, for the granted port only. All req_ready are 0 in every other state.
  - On handshake: latch we/maskmode/sext/addr/wdata and the port id; last_grant <= id.
  - If the request is legal, go to ACCESS; if not, go to RESP with err=1 and rdata=0.
- Legality:
  - maskmode != 11.
  - Half: addr[0]=0. Word: addr[1:0]=00. Byte: any offset.
  - addr < 4*2**MEM_ADDR_SIZE.
- ACCESS (exactly 1 cycle):
  - dm_address, dm_maskmode, dm_sext and dm_write_data are driven from the latched request.
  - Store: dm_mem_write=1, dm_mem_read=0; the memory commits on that cycle's negedge.
  - Load: dm_mem_read=1; rsp_rdata <= dm_read_data at the closing posedge.
  - Go to RESP.
- dm_* outputs outside ACCESS: all 0, so the memory sees no read or write.
- RESP:
  - rsp_valid=1 on the owning port only.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1. On that edge, go to IDLE and clear rsp_valid.
  - The other port's requests keep waiting; req_valid may be held indefinitely.
- Latency and throughput:
  - Legal request accepted at edge T gives rsp_valid=1 from edge T+2.
  - Illegal request accepted at edge T gives rsp_valid=1 from edge T+1.
  - Minimum of 3 cycles per legal transaction.
- Fairness: when both ports are continuously valid, grants strictly alternate.
- Simultaneous events: a new req_valid arriving during ACCESS or RESP is not seen until IDLE. A req_valid drop before handshake withdraws that port.
- Reset mid-operation: dm_mem_write is deasserted immediately. A store whose negedge has not yet occurred is dropped, and any pending response is discarded.

Test Plan:
- Reset, then m0 stores word 0xDEADBEEF at addr 0x10 (rsp_ready=1), then loads addr 0x10 with maskmode=10 -> dm_mem_write high for exactly 1 cycle; load response rdata=0xDEADBEEF, err=0, rsp_valid at T+2.
- m0 and m1 assert loads in the same cycle and hold them -> m0 is granted first, then m1, then m0; responses appear only on the granted port, and req_ready is never high on both ports.
- m1 issues a half load at addr 0x13, a word load at addr 0x22, maskmode=11, then a load at addr 0x400 (MEM_ADDR_SIZE=8) -> each gives err=1, rdata=0 at T+1; dm_mem_read and dm_mem_write stay 0 throughout.
- m0 load completes while rsp_ready is held 0 for 5 cycles, with m1 valid -> rsp_valid and rdata are held stable; m1 req_ready stays 0 until the cycle after m0 consumes the response.
- Byte load of a word holding 0x000000F0 with sext=0 vs sext=1 -> dm_sext mirrors the request; rdata=0xFFFFFFF0 and 0x000000F0 respectively.
- rstn pulsed low during the ACCESS cycle of a store, before the negedge -> all outputs go to 0 immediately; a subsequent load of that address returns the old value.
